// File: rtl/boot_rom_overlay.sv
// Boot ROM overlay: serves low CPU reads from a 256x8 sync PROM while boot is active,
// owns the 0xFF50 boot-disable register and forwards everything else to the cart bus.
module boot_rom_overlay #(
    parameter int unsigned CART_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        prom_ce,
    output logic        prom_oce,
    output logic        prom_reset,
    output logic [7:0]  prom_ad,
    input  logic [7:0]  prom_dout,
    output logic        cart_req,
    output logic        cart_we,
    output logic [15:0] cart_addr,
    output logic [7:0]  cart_wdata,
    input  logic [7:0]  cart_rdata,
    input  logic        cart_ack,
    output logic        boot_active,
    output logic        cart_timeout
);

    localparam logic [15:0] LP_TIMEOUT = 16'(CART_TIMEOUT);
    localparam logic [15:0] LP_CTRL    = 16'hFF50;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_RD,
        S_P_DATA,
        S_C_WAIT,
        S_ACK
    } state_t;

    state_t      r_state;
    logic [7:0]  r_rdata;
    logic        r_ack;
    logic        r_prom_ce;
    logic [7:0]  r_prom_ad;
    logic        r_cart_req;
    logic        r_cart_we;
    logic [15:0] r_cart_addr;
    logic [7:0]  r_cart_wdata;
    logic        r_boot;
    logic        r_timeout;
    logic [15:0] r_wait_cnt;

    logic        w_is_ctrl;
    logic        w_is_boot_rd;
    logic [15:0] w_cnt_next;

    assign w_is_ctrl    = (cpu_addr == LP_CTRL);
    assign w_is_boot_rd = r_boot && !cpu_we && (cpu_addr[15:8] == 8'h00);
    assign w_cnt_next   = r_wait_cnt + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rdata      <= 8'h00;
            r_ack        <= 1'b0;
            r_prom_ce    <= 1'b0;
            r_prom_ad    <= 8'h00;
            r_cart_req   <= 1'b0;
            r_cart_we    <= 1'b0;
            r_cart_addr  <= 16'h0000;
            r_cart_wdata <= 8'h00;
            r_boot       <= 1'b1;
            r_timeout    <= 1'b0;
            r_wait_cnt   <= 16'h0000;
        end else begin
            r_ack     <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (w_is_ctrl) begin
                            if (cpu_we) begin
                                if (cpu_wdata != 8'h00) r_boot <= 1'b0;
                            end else begin
                                r_rdata <= {7'b1111111, ~r_boot};
                            end
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                        end else if (w_is_boot_rd) begin
                            r_prom_ad <= cpu_addr[7:0];
                            r_prom_ce <= 1'b1;
                            r_state   <= S_P_RD;
                        end else begin
                            r_cart_req   <= 1'b1;
                            r_cart_we    <= cpu_we;
                            r_cart_addr  <= cpu_addr;
                            r_cart_wdata <= cpu_wdata;
                            r_wait_cnt   <= 16'h0000;
                            r_state      <= S_C_WAIT;
                        end
                    end
                end
                S_P_RD: begin
                    r_prom_ce <= 1'b0;
                    r_state   <= S_P_DATA;
                end
                S_P_DATA: begin
                    r_rdata <= prom_dout;
                    r_ack   <= 1'b1;
                    r_state <= S_ACK;
                end
                S_C_WAIT: begin
                    // cart_ack is checked first so a late ack in the timeout cycle still wins
                    if (cart_ack) begin
                        if (!r_cart_we) r_rdata <= cart_rdata;
                        r_cart_req <= 1'b0;
                        r_ack      <= 1'b1;
                        r_state    <= S_ACK;
                    end else begin
                        r_wait_cnt <= w_cnt_next;
                        if (w_cnt_next == LP_TIMEOUT) begin
                            if (!r_cart_we) r_rdata <= 8'hFF;
                            r_cart_req <= 1'b0;
                            r_timeout  <= 1'b1;
                            r_ack      <= 1'b1;
                            r_state    <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_prom_ce  <= 1'b0;
                    r_cart_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata    = r_rdata;
    assign cpu_ack      = r_ack;
    assign prom_ce      = r_prom_ce;
    assign prom_oce     = 1'b1;
    assign prom_reset   = ~reset_n;
    assign prom_ad      = r_prom_ad;
    assign cart_req     = r_cart_req;
    assign cart_we      = r_cart_we;
    assign cart_addr    = r_cart_addr;
    assign cart_wdata   = r_cart_wdata;
    assign boot_active  = r_boot;
    assign cart_timeout = r_timeout;

endmodule

// File: tb/tb_boot_rom_overlay.sv
// Randomized + directed bench for boot_rom_overlay against a transaction-level model
// (boot flag, last read data, expected latency/bus activity per access).
module tb_boot_rom_overlay;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        prom_ce, prom_oce, prom_reset;
    logic [7:0]  prom_ad;
    logic [7:0]  prom_dout = 8'h00;
    logic        cart_req, cart_we;
    logic [15:0] cart_addr;
    logic [7:0]  cart_wdata;
    logic [7:0]  cart_rdata = 8'h00;
    logic        cart_ack = 1'b0;
    logic        boot_active, cart_timeout;

    boot_rom_overlay #(.CART_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .prom_ce(prom_ce), .prom_oce(prom_oce), .prom_reset(prom_reset),
        .prom_ad(prom_ad), .prom_dout(prom_dout),
        .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr),
        .cart_wdata(cart_wdata), .cart_rdata(cart_rdata), .cart_ack(cart_ack),
        .boot_active(boot_active), .cart_timeout(cart_timeout)
    );

    always #5 clk = ~clk;

    // 256x8 PROM with one-cycle synchronous read
    logic [7:0] rom [256];
    always @(posedge clk) if (prom_ce) prom_dout <= rom[prom_ad];

    int n_chk = 0, n_pass = 0, n_fail = 0;
    bit         m_boot;
    logic [7:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU access; delay = cart wait cycles before cart_ack (0 = never)
    task automatic access(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                          input int delay, input logic [7:0] cdata);
        int ack_cyc = -1, n_ack = 0, n_prom = 0, prom_bad = 0;
        int n_creq = 0, creq_bad = 0, n_to = 0;
        int e_ack, e_creq, e_to, e_prom;
        logic [7:0] rd = 8'hxx;
        bit is_ctrl = (addr == 16'hFF50);
        bit is_prom = !is_ctrl && m_boot && !we && (addr < 16'h0100);
        e_creq = 0; e_to = 0; e_prom = 0;
        if (is_ctrl) begin
            e_ack = 1;
            if (!we) m_rdata = {7'h7F, ~m_boot};
            else if (wd != 8'h00) m_boot = 1'b0;
        end else if (is_prom) begin
            e_ack = 3; e_prom = 1;
            m_rdata = rom[addr[7:0]];
        end else if (delay >= 1 && delay <= TO) begin
            e_creq = delay; e_ack = delay + 1;
            if (!we) m_rdata = cdata;
        end else begin
            e_creq = TO; e_ack = TO + 1; e_to = 1;
            if (!we) m_rdata = 8'hFF;
        end

        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (prom_ce) begin
                n_prom++;
                if (cyc != 1 || prom_ad !== addr[7:0]) prom_bad++;
            end
            if (cart_req) begin
                n_creq++;
                if (cart_addr !== addr || cart_we !== we || cart_wdata !== wd) creq_bad++;
                cart_ack = (n_creq == delay);
                cart_rdata = (n_creq == delay) ? cdata : 8'($urandom);
            end else begin
                cart_ack = 1'b0;
            end
            if (cart_timeout) n_to++;
            if (cpu_ack) begin
                n_ack++;
                if (ack_cyc < 0) begin
                    ack_cyc = cyc;
                    rd = cpu_rdata;
                end
                cpu_req = 1'b0;
            end
            if (ack_cyc > 0 && cyc >= ack_cyc + 1) break;
        end
        cpu_req = 1'b0;
        cart_ack = 1'b0;
        chk($sformatf("ack_cycle@%h", addr), ack_cyc, e_ack);
        chk("ack_count", n_ack, 1);
        chk("prom_ce_cycles", n_prom, e_prom);
        chk("prom_ad_timing", prom_bad, 0);
        chk("cart_req_cycles", n_creq, e_creq);
        chk("cart_bus_stable", creq_bad, 0);
        chk("cart_timeout_pulses", n_to, e_to);
        chk("cpu_rdata", rd, m_rdata);
        chk("boot_active", boot_active, m_boot);
    endtask

    task automatic rand_accesses(input int n);
        for (int i = 0; i < n; i++) begin
            int kind = $urandom_range(0, 3);
            bit we = 1'($urandom);
            logic [15:0] a = 16'($urandom);
            logic [7:0] wd = 8'($urandom);
            if (kind == 0) a = {8'h00, a[7:0]};
            else if (kind == 1) begin
                a = 16'hFF50;
                if ($urandom_range(0, 7) != 0) wd = 8'h00;
            end else if (a == 16'hFF50) a = 16'hFF51;
            access(we, a, wd, $urandom_range(0, 6), 8'($urandom));
        end
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h31;
        m_boot = 1'b1;
        m_rdata = 8'h00;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_cart_req", cart_req, 0);
        chk("rst_cart_addr", cart_addr, 16'h0000);
        chk("rst_cart_wdata", cart_wdata, 8'h00);
        chk("rst_cart_we", cart_we, 0);
        chk("rst_prom_ce", prom_ce, 0);
        chk("rst_boot_active", boot_active, 1);
        chk("rst_cart_timeout", cart_timeout, 0);
        chk("rst_prom_reset", prom_reset, 1);
        chk("prom_oce", prom_oce, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 chk("prom_reset_released", prom_reset, 0);

        access(0, 16'h0000, 8'h00, 1, 8'h00);        // PROM byte 0x31
        access(1, 16'hFF50, 8'h00, 1, 8'h00);        // zero write keeps boot
        access(0, 16'h00FF, 8'h00, 1, 8'h00);
        access(0, 16'hFF50, 8'h00, 1, 8'h00);        // reads 0xFE
        access(1, 16'h2000, 8'h05, 3, 8'hAA);        // MBC write while booting
        access(0, 16'h8000, 8'h00, TO, 8'h5A);       // ack in timeout cycle wins
        access(0, 16'h9000, 8'h00, 0, 8'h00);        // timeout -> 0xFF
        access(0, 16'h4000, 8'h00, 1, 8'h77);
        rand_accesses(30);

        access(1, 16'hFF50, 8'h01, 1, 8'h00);        // disable boot
        access(0, 16'hFF50, 8'h00, 1, 8'h00);
        access(0, 16'h0000, 8'h00, 2, 8'hC3);        // now from cart
        access(1, 16'hFF50, 8'h00, 1, 8'h00);
        rand_accesses(10);

        // reset in the middle of a cart wait
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_reset_cart_req", cart_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_cart_req", cart_req, 0);
        chk("midrst_cpu_ack", cpu_ack, 0);
        chk("midrst_boot_active", boot_active, 1);
        cpu_req = 1'b0;
        m_boot = 1'b1;
        m_rdata = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        repeat (6) begin @(posedge clk); #1; if (cpu_ack) acks++; end
        chk("post_reset_no_ack", acks, 0);
        access(0, 16'h0001, 8'h00, 1, 8'h99);
        rand_accesses(15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
